dm_responder: RTL

- Data-side memory responder: the target end of the core's data-memory access path (address, write data, write enable, byte enables).
- Accepts one request at a time over a valid/ready handshake. Holds it for a programmable number of wait states, performs the word access on an internal RAM, then returns a response over a second valid/ready handshake.
- Lets the datapath be exercised against a memory with non-zero latency and backpressure.
- Clears its RAM by a hardware sweep after every reset.

---
 rtl/dm_pkg.sv | 23 ++
 rtl/dm_if.sv | 27 ++
 rtl/dm_ram.sv | 23 ++
 rtl/dm_responder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} dmState_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] pc;
  } dmRsp_t;

  // Expand byte enables into a 32-bit lane mask.
  function automatic logic [31:0] laneMask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/dm_if.sv
// Request/response handshake bundle between the core data port and the responder.
interface dm_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] rsp_pc;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_pc
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_pc
  );

endinterface

// File: rtl/dm_ram.sv
// Single-port synchronous word RAM with per-byte write enables and registered read.
module dm_ram #(
  parameter int DEPTH_WORDS = 3072,
  parameter int AW          = 12
) (
  input  logic          clk,
  input  logic [3:0]    wrBe,
  input  logic          rdEn,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wrBe[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (rdEn) rdata <= mem[addr];
  end

endmodule

// File: rtl/dm_responder.sv
// Data-side memory responder: one outstanding request, programmable wait states,
// byte-lane access to an internal RAM that is swept to zero after every reset.
module dm_responder
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  dm_if.slave  bus
);

  localparam int            AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH_WORDS - 1);
  localparam logic [32:0]   SPAN      = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]    WAIT_INIT = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gBadWait
    $error("dm_responder: WAIT_CYCLES must be within 0..15");
  end

  dmState_t      state, stateNxt;
  logic [AW-1:0] clrIdx;
  logic [3:0]    waitCnt;
  logic          reqWe;
  logic [3:0]    reqBe;
  logic [31:0]   reqAddr, reqWdata, reqPc;
  logic          rspErr;
  logic [3:0]    rspBe;
  logic [31:0]   rspPc;
  logic [32:0]   offset;
  logic          inRange, accErr, accEdge, accept, rspDone;
  logic [3:0]    ramBe;
  logic          ramRd;
  logic [AW-1:0] ramAddr;
  logic [31:0]   ramWdata, ramQ;
  dmRsp_t        rsp;

  assign accept  = bus.req_valid && bus.req_ready;
  assign rspDone = bus.rsp_valid && bus.rsp_ready;

  // Bit 32 of the difference is the borrow: set when addr < BASE_ADDR.
  assign offset  = {1'b0, reqAddr} - {1'b0, BASE_ADDR};
  assign inRange = !offset[32] && (offset < SPAN);
  assign accErr  = (reqAddr[1:0] != 2'b00) || !inRange || (reqBe == BE_NONE);
  assign accEdge = (state == WAIT) && (waitCnt == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clrIdx  <= '0;
      waitCnt <= '0;
      rspErr  <= 1'b0;
      rspBe   <= BE_NONE;
      rspPc   <= '0;
    end else begin
      state <= stateNxt;
      if (state == CLEAR) clrIdx <= (clrIdx == LAST_IDX) ? '0 : clrIdx + 1'b1;
      if (accept) waitCnt <= WAIT_INIT;
      else if ((state == WAIT) && (waitCnt != 4'd0)) waitCnt <= waitCnt - 1'b1;
      // Writes and errors keep a zero lane mask so rsp_rdata reads back as 0.
      if (accEdge) begin
        rspErr <= accErr;
        rspBe  <= (reqWe || accErr) ? BE_NONE : reqBe;
        rspPc  <= reqPc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      reqWe    <= bus.req_we;
      reqBe    <= bus.req_be;
      reqAddr  <= bus.req_addr;
      reqWdata <= bus.req_wdata;
      reqPc    <= bus.req_pc;
    end
  end

  always_comb begin
    stateNxt      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      CLEAR: if (clrIdx == LAST_IDX) stateNxt = IDLE;
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) stateNxt = WAIT;
      end
      WAIT: if (waitCnt == 4'd0) stateNxt = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (rspDone) stateNxt = IDLE;
      end
      default: stateNxt = CLEAR;
    endcase
  end

  // RAM port is owned by the clear sweep in CLEAR, by the access edge otherwise.
  always_comb begin
    ramBe    = BE_NONE;
    ramRd    = 1'b0;
    ramAddr  = offset[AW+1:2];
    ramWdata = reqWdata;
    if (state == CLEAR) begin
      ramBe    = BE_WORD;
      ramAddr  = clrIdx;
      ramWdata = '0;
    end else if (accEdge && !accErr) begin
      if (reqWe) ramBe = reqBe;
      else       ramRd = 1'b1;
    end
  end

  dm_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) uRam (
    .clk  (clk),
    .wrBe (ramBe),
    .rdEn (ramRd),
    .addr (ramAddr),
    .wdata(ramWdata),
    .rdata(ramQ)
  );

  assign rsp.rdata     = ramQ & laneMask(rspBe);
  assign rsp.err       = rspErr;
  assign rsp.pc        = rspPc;
  assign bus.rsp_rdata = rsp.rdata;
  assign bus.rsp_err   = rsp.err;
  assign bus.rsp_pc    = rsp.pc;

endmodule
